// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
//   fetch_state_t   : request FSM states (IDLE, WAIT_RSP, DROP)
//   fetch_entry_t   : one queued {pc, instr} pair handed to decode
//   DEFAULT_ADDR_W  : PC / memory address width the entry struct is built for
//   DEFAULT_INSTR_W : instruction width the entry struct is built for
package fetch_pkg;

    localparam int DEFAULT_ADDR_W  = 32;
    localparam int DEFAULT_INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RSP = 2'd1,
        DROP     = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0]  pc;
        logic [DEFAULT_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch_entry_t between memory response and decode.
//   clk, rst   : clock, asynchronous active-high reset
//   push/wdata : write one entry (ignored when full unless popping the same cycle)
//   pop        : remove the head entry (ignored when empty)
//   flush      : empty the queue at the next edge; wins over push and pop
//   head       : current head entry, all-zero when empty
//   count      : number of valid entries (0..DEPTH)
//   full/empty : occupancy flags
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               wdata,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A pop frees the slot the simultaneous push fills, so push-when-full is legal then.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, regardless of block ordering in simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; validity is tracked solely by count/pointers,
    // which keeps the array as plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues instruction-memory reads at the current PC, buffers the
// returned {pc, instr} pairs and presents them to decode.
//   clk, rst                     : clock, asynchronous active-high reset
//   pc_in, redirect              : current PC and non-sequential PC load strobe
//   pc_advance                   : tells the PC to step by 4 at the next edge
//   imem_req_valid/ready/addr    : read request channel (one outstanding max)
//   imem_rsp_valid/data          : single-cycle read response, never stalled
//   dec_valid/ready/instr/pc     : queue head towards decode
//   fault, fault_pc              : sticky misaligned-fetch flag and offending PC
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int QDEPTH  = 2,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int INSTR_W = DEFAULT_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               redirect,
    output logic               pc_advance,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic               fault,
    output logic [ADDR_W-1:0]  fault_pc
);

    localparam int CW = $clog2(QDEPTH) + 1;

    // The queue entry struct is sized by the package, so widths must agree.
    if (ADDR_W != DEFAULT_ADDR_W || INSTR_W != DEFAULT_INSTR_W) begin : g_width_check
        $error("instr_fetch_unit: ADDR_W/INSTR_W must match fetch_pkg defaults");
    end
    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_depth_check
        $error("instr_fetch_unit: QDEPTH must be a power of 2 and >= 2");
    end

    fetch_state_t        state;
    logic [ADDR_W-1:0]   req_pc;

    fetch_entry_t        q_wdata;
    fetch_entry_t        q_head;
    logic [CW-1:0]       q_count;
    logic                q_full;
    logic                q_empty;
    logic                q_push;
    logic                q_pop;

    logic                inflight;
    logic                slot_free;
    logic                aligned;
    logic                req_accept;

    // Credit rule: queued entries plus the outstanding read never exceed QDEPTH.
    assign inflight  = (state != IDLE);
    assign slot_free = (q_count + CW'(inflight)) < CW'(QDEPTH);
    assign aligned   = (pc_in[1:0] == 2'b00);

    // Gated by rst so nothing is requested (and all outputs read 0) while held in reset.
    assign imem_req_valid = !rst && (state == IDLE) && !redirect && !fault
                            && aligned && slot_free;
    assign imem_req_addr  = pc_in;
    assign req_accept     = imem_req_valid && imem_req_ready;
    assign pc_advance     = req_accept;

    // A response coinciding with a redirect belongs to the old path and is dropped.
    assign q_push  = (state == WAIT_RSP) && imem_rsp_valid && !redirect;
    assign q_pop   = dec_ready && !q_empty;
    assign q_wdata = '{pc: req_pc, instr: imem_rsp_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            req_pc   <= '0;
            fault    <= 1'b0;
            fault_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_accept) begin
                        req_pc <= pc_in;
                        state  <= WAIT_RSP;
                    end
                    // Only the first misaligned PC is recorded; the flag is sticky.
                    if (!redirect && !aligned && !fault) begin
                        fault    <= 1'b1;
                        fault_pc <= pc_in;
                    end
                end
                WAIT_RSP: begin
                    if (imem_rsp_valid)  state <= IDLE;
                    else if (redirect)   state <= DROP;
                end
                DROP: begin
                    // Swallow the stale response of the request issued before the redirect.
                    if (imem_rsp_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .wdata (q_wdata),
        .pop   (q_pop),
        .flush (redirect),
        .head  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign dec_valid = !q_empty;
    assign dec_instr = q_head.instr;
    assign dec_pc    = q_head.pc;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(q_push && q_full && !q_pop));

    a_no_rsp_in_idle: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && state == IDLE));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit. Inputs change 1 time unit
// after the rising edge; outputs are compared mid-cycle, away from the edge.
module tb_instr_fetch_unit;

    localparam int AW = 32;
    localparam int IW = 32;

    logic          clk;
    logic          rst;
    logic [AW-1:0] pc_in;
    logic          redirect;
    logic          pc_advance;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_data;
    logic          dec_valid;
    logic          dec_ready;
    logic [IW-1:0] dec_instr;
    logic [AW-1:0] dec_pc;
    logic          fault;
    logic [AW-1:0] fault_pc;

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch_unit #(
        .QDEPTH  (2),
        .ADDR_W  (AW),
        .INSTR_W (IW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .redirect       (redirect),
        .pc_advance     (pc_advance),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        pc_in          = '0;
        redirect       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        dec_ready      = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        pc_in          = '0;
        redirect       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        dec_ready      = 1'b0;
        #2;
        // Reset state
        check("rst_req_valid",  64'(imem_req_valid), 64'h0);
        check("rst_pc_advance", 64'(pc_advance),     64'h0);
        check("rst_dec_valid",  64'(dec_valid),      64'h0);
        check("rst_dec_instr",  64'(dec_instr),      64'h0);
        check("rst_dec_pc",     64'(dec_pc),         64'h0);
        check("rst_fault",      64'(fault),          64'h0);
        check("rst_fault_pc",   64'(fault_pc),       64'h0);
        tick();
        tick();
        rst = 1'b0;

        // T1: single fetch, 1-cycle memory, decode always ready
        pc_in = 32'h0; imem_req_ready = 1'b1; dec_ready = 1'b1; #1;
        check("t1_req_valid",  64'(imem_req_valid), 64'h1);
        check("t1_req_addr",   64'(imem_req_addr),  64'h0);
        check("t1_pc_advance", 64'(pc_advance),     64'h1);
        tick();
        pc_in = 32'h4; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2001_0005; #1;
        check("t1_wait_no_req",   64'(imem_req_valid), 64'h0);
        check("t1_wait_no_dec",   64'(dec_valid),      64'h0);
        tick();
        imem_rsp_valid = 1'b0; #1;
        check("t1_dec_valid", 64'(dec_valid), 64'h1);
        check("t1_dec_pc",    64'(dec_pc),    64'h0);
        check("t1_dec_instr", 64'(dec_instr), 64'h2001_0005);
        tick();
        check("t1_popped",      64'(dec_valid),  64'h0);
        check("t1_no_advance",  64'(pc_advance), 64'h0);

        // T2: decode stalled, queue fills to 2 then requests stop
        do_reset();
        pc_in = 32'h0; imem_req_ready = 1'b1; dec_ready = 1'b0; #1;
        check("t2_first_adv", 64'(pc_advance), 64'h1);
        tick();
        pc_in = 32'h4; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_0000; #1;
        tick();
        imem_rsp_valid = 1'b0; #1;
        check("t2_one_queued",  64'(dec_valid),      64'h1);
        check("t2_second_req",  64'(imem_req_valid), 64'h1);
        check("t2_second_addr", 64'(imem_req_addr),  64'h4);
        tick();
        pc_in = 32'h8; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2222_0004; #1;
        tick();
        imem_rsp_valid = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            check("t2_full_no_req", 64'(imem_req_valid), 64'h0);
            check("t2_full_no_adv", 64'(pc_advance),     64'h0);
            tick();
        end
        imem_req_ready = 1'b0; dec_ready = 1'b1; #1;
        check("t2_head0_pc",    64'(dec_pc),    64'h0);
        check("t2_head0_instr", 64'(dec_instr), 64'h1111_0000);
        tick();
        check("t2_head1_pc",    64'(dec_pc),    64'h4);
        check("t2_head1_instr", 64'(dec_instr), 64'h2222_0004);
        tick();
        check("t2_drained", 64'(dec_valid), 64'h0);

        // T3: redirect one cycle after accept, stale response two cycles after accept
        do_reset();
        pc_in = 32'h0; imem_req_ready = 1'b1; dec_ready = 1'b1; #1;
        check("t3_accept", 64'(pc_advance), 64'h1);
        tick();
        pc_in = 32'h4; redirect = 1'b1; #1;
        check("t3_redir_no_req", 64'(imem_req_valid), 64'h0);
        check("t3_redir_no_adv", 64'(pc_advance),     64'h0);
        tick();
        redirect = 1'b0; pc_in = 32'h100;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; #1;
        check("t3_drop_no_req", 64'(imem_req_valid), 64'h0);
        tick();
        imem_rsp_valid = 1'b0; #1;
        check("t3_discarded", 64'(dec_valid),      64'h0);
        check("t3_new_req",   64'(imem_req_valid), 64'h1);
        check("t3_new_addr",  64'(imem_req_addr),  64'h100);
        check("t3_new_adv",   64'(pc_advance),     64'h1);
        tick();
        pc_in = 32'h104; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0513; #1;
        tick();
        imem_rsp_valid = 1'b0; #1;
        check("t3_dec_pc",    64'(dec_pc),    64'h100);
        check("t3_dec_instr", 64'(dec_instr), 64'h0000_0513);
        tick();

        // T4: redirect together with a response while the queue holds an entry
        do_reset();
        pc_in = 32'h0; imem_req_ready = 1'b1; dec_ready = 1'b0; #1;
        tick();
        pc_in = 32'h4; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hAAAA_0000; #1;
        tick();
        imem_rsp_valid = 1'b0; #1;
        check("t4_queued",     64'(dec_valid),  64'h1);
        check("t4_second_adv", 64'(pc_advance), 64'h1);
        tick();
        pc_in = 32'h8; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBBBB_0004;
        redirect = 1'b1; dec_ready = 1'b1; #1;
        check("t4_redir_no_adv",   64'(pc_advance), 64'h0);
        check("t4_pre_flush_head", 64'(dec_valid),  64'h1);
        tick();
        imem_rsp_valid = 1'b0; dec_ready = 1'b0; redirect = 1'b1; #1;
        check("t4_flushed",        64'(dec_valid),      64'h0);
        check("t4_flushed_pc",     64'(dec_pc),         64'h0);
        check("t4_flushed_instr",  64'(dec_instr),      64'h0);
        check("t4_idle_redir_req", 64'(imem_req_valid), 64'h0);
        check("t4_idle_redir_adv", 64'(pc_advance),     64'h0);
        tick();
        redirect = 1'b0; pc_in = 32'h200; #1;
        check("t4_resume_req",  64'(imem_req_valid), 64'h1);
        check("t4_resume_addr", 64'(imem_req_addr),  64'h200);

        // T5: misaligned PC raises a sticky fault, cleared only by async reset
        do_reset();
        pc_in = 32'hFFFF_FFFF; imem_req_ready = 1'b1; #1;
        check("t5_no_req",       64'(imem_req_valid), 64'h0);
        check("t5_no_adv",       64'(pc_advance),     64'h0);
        check("t5_fault_before", 64'(fault),          64'h0);
        tick();
        check("t5_fault",    64'(fault),    64'h1);
        check("t5_fault_pc", 64'(fault_pc), 64'hFFFF_FFFF);
        pc_in = 32'h0; #1;
        check("t5_blocked", 64'(imem_req_valid), 64'h0);
        tick();
        pc_in = 32'h6;
        tick();
        check("t5_sticky",    64'(fault),    64'h1);
        check("t5_sticky_pc", 64'(fault_pc), 64'hFFFF_FFFF);
        #2;
        rst = 1'b1; #1;
        check("t5_async_clr",    64'(fault),    64'h0);
        check("t5_async_clr_pc", 64'(fault_pc), 64'h0);
        tick();
        rst = 1'b0; pc_in = 32'h0; imem_req_ready = 1'b0;

        // T6: memory not ready for 5 cycles; request held stable, no advance
        pc_in = 32'h40; imem_req_ready = 1'b0; dec_ready = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            check("t6_hold_valid", 64'(imem_req_valid), 64'h1);
            check("t6_hold_addr",  64'(imem_req_addr),  64'h40);
            check("t6_hold_adv",   64'(pc_advance),     64'h0);
            tick();
        end
        imem_req_ready = 1'b1; #1;
        check("t6_accept_adv",  64'(pc_advance),    64'h1);
        check("t6_accept_addr", 64'(imem_req_addr), 64'h40);
        tick();
        pc_in = 32'h44; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0040_0093; #1;
        tick();
        imem_rsp_valid = 1'b0; #1;
        check("t6_dec_pc",    64'(dec_pc),    64'h40);
        check("t6_dec_instr", 64'(dec_instr), 64'h0040_0093);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly downstream of the program counter. It takes the current PC, issues a read to instruction memory over a valid/ready request channel, and accepts the response. Fetched {pc, instruction} pairs are buffered in a small queue that feeds decode over a valid/ready handshake. The block also drives the PC-advance strobe and flushes itself whenever the PC is redirected by a jump, branch or register load.

Parameters:
QDEPTH, 2, instruction queue depth in entries (power of 2, >=2)
ADDR_W, 32, PC and memory address width
INSTR_W, 32, instruction width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
pc_in  in  ADDR_W  current PC from program counter
redirect  in  1  high when PC is loaded non-sequentially this cycle (pc_control != 4'b0000)
pc_advance  out  1  strobe to program counter: step PC by 4 at next edge
imem_req_valid  out  1  memory read request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  read address
imem_rsp_valid  in  1  read data valid (single cycle, never back-pressured)
imem_rsp_data  in  INSTR_W  read data
dec_valid  out  1  queue head valid
dec_ready  in  1  decode accepts head
dec_instr  out  INSTR_W  head instruction
dec_pc  out  ADDR_W  PC of head instruction
fault  out  1  sticky misaligned-fetch flag
fault_pc  out  ADDR_W  PC that caused the fault

Behaviour:
- Reset (async): state=IDLE; queue empty; fault=0; fault_pc=0. All outputs are 0; dec_instr and dec_pc read 0 when the queue is empty.
- At most one request is outstanding. A request may issue only when count + outstanding < QDEPTH.
- FSM states: IDLE, WAIT_RSP, DROP.
- IDLE:
  - imem_req_valid = !redirect && !fault && pc_in[1:0]==0 && slot free.
  - imem_req_addr = pc_in.
  - On valid&&ready: latch req_pc=pc_in, go to WAIT_RSP.
  - pc_advance = imem_req_valid && imem_req_ready. It is combinational in the accept cycle, so the PC steps at the next edge.
- WAIT_RSP:
  - On rsp_valid && !redirect: push {req_pc, rsp_data}, go to IDLE.
  - On rsp_valid && redirect: discard the data, go to IDLE.
  - On redirect without rsp: go to DROP.
- DROP: the first rsp_valid is discarded, then go to IDLE. imem_req_valid=0 in this state.
- Redirect in any state:
  - Queue flushes at the next edge (count=0, pointers reset).
  - No request issues in the redirect cycle, and pc_advance=0.
  - A pop in the same cycle is ignored, since the flush wins.
- Misaligned PC: in IDLE with pc_in[1:0]!=0 and !redirect, no request is issued. fault<=1 and fault_pc<=pc_in. Both hold until reset. This covers pc_in=32'hFFFF_FFFF from an undefined PC control code.
- Queue behaviour:
  - Registered FIFO; push and pop may occur in the same cycle, including when full (pop frees a slot, push fills it).
  - Overflow is impossible by credit rule. Assertion: push && full && !pop never occurs.
  - Pop only when dec_valid && dec_ready.
  - dec_valid = count!=0, output from registers.
- Latency:
  - Request accepted at cycle N; response earliest N+1; dec_valid earliest N+2.
  - Throughput with 1-cycle memory: one instruction per 2 cycles.
- Memory responses arriving in IDLE (protocol violation) are ignored. Assertion flags this.
- Reset mid-operation drops any outstanding response. The memory side must also be reset.

Decomposition:
- Package fetch_pkg holds:
  - the fetch_state_t enum {IDLE, WAIT_RSP, DROP}
  - ADDR_W/INSTR_W defaults
  - the fetch_entry_t struct {pc, instr}
- Sub-module fetch_queue: parameterised sync FIFO with push, pop, flush, count, full/empty, holding fetch_entry_t.

Test Plan:
- Reset, then pc_in=0x0, req_ready=1, 1-cycle memory returning 0x20010005, dec_ready=1 -> req at cycle 1 with addr 0x0, pc_advance pulse, dec_valid at cycle 3 with dec_pc=0, dec_instr=0x20010005.
- dec_ready=0 with continuous fetch -> exactly 2 entries queued, then imem_req_valid stays 0. Raising dec_ready drains pc 0x0, then 0x4, in order.
- redirect one cycle after request accept with response 2 cycles later -> enter DROP, response discarded, queue empty. Next request uses the new pc_in (e.g. 0x100).
- redirect coincident with rsp_valid and a non-empty queue -> data discarded, dec_valid=0 next cycle, pc_advance=0 that cycle.
- pc_in=0xFFFFFFFF -> no request, fault=1, fault_pc=0xFFFFFFFF, sticky until rst. rst clears fault to 0 asynchronously.
- imem_req_ready held low for 5 cycles -> imem_req_valid and addr stable, pc_advance stays 0 until accept.
